// File: rtl/seq_pipe_addn.sv
// seq_pipe_addn: pipelined unsigned adder tree summing NIN operands of WIDTH
// bits, one tree level per pipeline stage, with valid/ready flow control and
// a sticky overflow flag.
//
// Parameters
//   WIDTH   bits per operand and per result (1..32)
//   NIN     operand count (2..16), need not be a power of two
// Ports
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset; clears every stage
//   in_val   operand set valid
//   in_rdy   operand set accepted this cycle (combinational, stall-driven)
//   in       packed operands, operand i at in[i*WIDTH +: WIDTH]
//   out_val  result valid
//   out_rdy  downstream accepts result
//   out      sum (mod 2^WIDTH, or saturated)
//   out_ovf  true sum was >= 2^WIDTH
// Build option
//   SEQ_PIPE_ADDN_SAT_EN  defined: saturating sums; undefined: wrap-around.
//
// Storage layout: every stage's entries live in one flat array. Level k holds
// lvl_cnt(k) entries starting at lvl_off(k); level 0 is the operand register.

// Pairwise add cell: one node of the tree.
module seq_pipe_addn_cell #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_ovf,
  input  logic             b_ovf,
  output logic [WIDTH-1:0] s,
  output logic             s_ovf
);
  logic [WIDTH:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign s_ovf = full[WIDTH] | a_ovf | b_ovf;
`ifdef SEQ_PIPE_ADDN_SAT_EN
  // Once any upstream add overflowed the true sum is already >= 2^WIDTH,
  // so pinning to all-ones here makes the final result min(sum, max).
  assign s = s_ovf ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
  assign s = full[WIDTH-1:0];
`endif
endmodule

module seq_pipe_addn #(
  parameter int WIDTH = 8,
  parameter int NIN   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [NIN*WIDTH-1:0] in,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     out,
  output logic                 out_ovf
);
  localparam int LEVELS = $clog2(NIN);

  // Entries at tree level k: NIN halved (rounding up) k times.
  function automatic int lvl_cnt(input int k);
    int n;
    n = NIN;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Index of the first entry of level k in the flat storage.
  function automatic int lvl_off(input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o += lvl_cnt(i);
    return o;
  endfunction

  localparam int TOT = lvl_off(LEVELS + 1);

  logic [TOT-1:0][WIDTH-1:0] sum_q, nxt_d;
  logic [TOT-1:0]            ovf_q, nxt_o;
  logic [LEVELS:0]           vld_pipe;
  logic                      en;

  // The whole pipe advances or holds as one; a full output blocks everything.
  assign en      = !out_val || out_rdy;
  assign in_rdy  = en;
  assign out_val = vld_pipe[LEVELS];
  assign out     = sum_q[TOT-1];
  assign out_ovf = ovf_q[TOT-1];

  for (genvar i = 0; i < NIN; i++) begin : g_s0
    assign nxt_d[i] = in[i*WIDTH +: WIDTH];
    assign nxt_o[i] = 1'b0;
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int PO = lvl_off(k - 1);
    localparam int PC = lvl_cnt(k - 1);
    localparam int CO = lvl_off(k);
    localparam int CC = lvl_cnt(k);
    for (genvar j = 0; j < CC; j++) begin : g_ent
      if (2*j + 1 < PC) begin : g_add
        seq_pipe_addn_cell #(.WIDTH(WIDTH)) u_cell (
          .a     (sum_q[PO + 2*j]),
          .b     (sum_q[PO + 2*j + 1]),
          .a_ovf (ovf_q[PO + 2*j]),
          .b_ovf (ovf_q[PO + 2*j + 1]),
          .s     (nxt_d[CO + j]),
          .s_ovf (nxt_o[CO + j])
        );
      end else begin : g_pass
        // Odd entry count: the last entry has no partner and moves down as-is.
        assign nxt_d[CO + j] = sum_q[PO + 2*j];
        assign nxt_o[CO + j] = ovf_q[PO + 2*j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q    <= '0;
      ovf_q    <= '0;
      vld_pipe <= '0;
    end else if (en) begin
      sum_q    <= nxt_d;
      ovf_q    <= nxt_o;
      vld_pipe <= {vld_pipe[LEVELS-1:0], in_val};
    end
  end
endmodule
